// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic PE array, its operand feeder and its result drain:
// derived width helpers and the collect/drain state encoding.
package systolic_pkg;

  // Result width of one PE: full product plus headroom for DIMENSION accumulations.
  function automatic int o_bits_f(input int i_bits, input int dimension);
    return (2 * i_bits) + $clog2(dimension);
  endfunction

  // Row/column index width, kept at least one bit for a 1x1 array.
  function automatic int idx_bits_f(input int dimension);
    return (dimension > 1) ? $clog2(dimension) : 1;
  endfunction

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DRAIN   = 1'b1
  } drain_state_t;

endpackage

// File: rtl/systolic_result_drain.sv
// Captures each PE result as its finish flag fires, then streams the completed matrix
// out row-major over valid/ready. One buffer; unhonoured captures raise a sticky overrun.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int O_BITS    = o_bits_f(I_BITS, DIMENSION)
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic [DIMENSION*DIMENSION*O_BITS-1:0] i_c,
  input  logic [DIMENSION*DIMENSION-1:0]        i_finish,
  output logic [O_BITS-1:0]                     o_data,
  output logic [idx_bits_f(DIMENSION)-1:0]      o_row,
  output logic [idx_bits_f(DIMENSION)-1:0]      o_col,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic                                  o_last,
  output logic                                  o_busy,
  output logic                                  o_overrun
);

  localparam int N        = DIMENSION * DIMENSION;
  localparam int IDX_BITS = idx_bits_f(DIMENSION);
  localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1;

  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(N - 1);
  localparam logic [PTR_BITS-1:0] PTR_DIM  = PTR_BITS'(DIMENSION);

  drain_state_t          state_q, state_d;
  logic [N-1:0]          mask_q, mask_d;
  logic [N-1:0]          cap_en;
  logic [PTR_BITS-1:0]   ptr_q, ptr_d;
  logic                  overrun_q, overrun_d;
  logic                  at_last;
  logic [N*O_BITS-1:0]   buf_flat;

  assign at_last = (ptr_q == PTR_LAST);

  // NOTE: every variable is given a default first so no path through the block leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    cap_en    = '0;

    case (state_q)
      ST_COLLECT: begin
        cap_en = i_finish & ~mask_q;
        if (|(i_finish & mask_q)) overrun_d = 1'b1;
        mask_d = mask_q | cap_en;
        if (&mask_d) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The buffer is full and owned by the drain; any new result is lost.
        if (|i_finish) overrun_d = 1'b1;
        if (i_ready) begin
          if (at_last) begin
            ptr_d   = '0;
            mask_d  = '0;
            state_d = ST_COLLECT;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of block evaluation order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_COLLECT;
      mask_q    <= '0;
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_elem
    logic [O_BITS-1:0] elem_q;

    // NOTE: the result buffer is reset like any other register so a drain after reset can
    // never present data captured before it.
    always_ff @(posedge i_clock) begin
      if (i_reset)        elem_q <= '0;
      else if (cap_en[k]) elem_q <= i_c[k*O_BITS +: O_BITS];
    end

    assign buf_flat[k*O_BITS +: O_BITS] = elem_q;
  end

  always_comb begin
    o_valid   = (state_q == ST_DRAIN);
    o_busy    = o_valid;
    o_overrun = overrun_q;
    o_last    = o_valid & at_last;
    o_data    = '0;
    o_row     = '0;
    o_col     = '0;
    if (o_valid) begin
      o_data = buf_flat[int'(ptr_q)*O_BITS +: O_BITS];
      o_row  = IDX_BITS'(ptr_q / PTR_DIM);
      o_col  = IDX_BITS'(ptr_q % PTR_DIM);
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized bench for systolic_result_drain against a queue-based reference model of the
// collect/drain behaviour, plus directed latency, backpressure, overrun and reset cases.
module tb_systolic_result_drain;

  localparam int DIM = 4;
  localparam int IB  = 8;
  localparam int OB  = 18;
  localparam int N   = DIM * DIM;

  logic            i_clock = 1'b0;
  logic            i_reset;
  logic [N*OB-1:0] i_c;
  logic [N-1:0]    i_finish;
  logic            i_ready;
  logic [OB-1:0]   o_data;
  logic [1:0]      o_row;
  logic [1:0]      o_col;
  logic            o_valid;
  logic            o_last;
  logic            o_busy;
  logic            o_overrun;

  systolic_result_drain #(.DIMENSION(DIM), .I_BITS(IB), .O_BITS(OB)) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_c      (i_c),
    .i_finish (i_finish),
    .o_data   (o_data),
    .o_row    (o_row),
    .o_col    (o_col),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_last   (o_last),
    .o_busy   (o_busy),
    .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    int            k;
    logic [OB-1:0] d;
  } beat_t;

  // Reference model: results gathered per element; a completed batch becomes a queue of beats.
  bit            cap [N];
  logic [OB-1:0] val [N];
  beat_t         q [$];
  bit            m_overrun;
  int            xfers;
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_c(input int k, input logic [OB-1:0] v);
    i_c[k*OB +: OB] = v;
  endtask

  // One clock: compare outputs mid-cycle, advance the model with the current inputs, take the edge.
  task automatic step();
    bit all_in;
    @(negedge i_clock);
    check("valid", o_valid, 64'(q.size() > 0));
    check("busy", o_busy, 64'(q.size() > 0));
    check("overrun", o_overrun, 64'(m_overrun));
    if (q.size() > 0) begin
      check("data", o_data, q[0].d);
      check("row", o_row, q[0].k / DIM);
      check("col", o_col, q[0].k % DIM);
      check("last", o_last, 64'(q[0].k == N - 1));
    end else begin
      check("last_idle", o_last, 0);
    end
    if (o_valid && i_ready) xfers++;

    if (i_reset) begin
      q.delete();
      for (int k = 0; k < N; k++) cap[k] = 1'b0;
      m_overrun = 1'b0;
    end else if (q.size() > 0) begin
      if (|i_finish) m_overrun = 1'b1;
      if (i_ready) void'(q.pop_front());
    end else begin
      all_in = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (i_finish[k]) begin
          if (cap[k]) m_overrun = 1'b1;
          else begin
            cap[k] = 1'b1;
            val[k] = i_c[k*OB +: OB];
          end
        end
      end
      for (int k = 0; k < N; k++) all_in &= cap[k];
      if (all_in) begin
        for (int k = 0; k < N; k++) begin
          q.push_back('{k, val[k]});
          cap[k] = 1'b0;
        end
      end
    end
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_finish = '0;
    i_reset  = 1'b1;
    step();
    i_reset  = 1'b0;
  endtask

  // All elements finish in one cycle with random values.
  task automatic fill_random();
    for (int k = 0; k < N; k++) set_c(k, OB'($urandom));
    i_finish = '1;
    step();
    i_finish = '0;
  endtask

  task automatic drain_out(input int budget);
    int n;
    i_finish = '0;
    i_ready  = 1'b1;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 64'(q.size()), 0);
    check("drain_idle", o_valid, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    xfers     = 0;
    m_overrun = 1'b0;
    for (int k = 0; k < N; k++) cap[k] = 1'b0;
    i_reset  = 1'b1;
    i_c      = '0;
    i_finish = '0;
    i_ready  = 1'b0;
    @(posedge i_clock);
    #1;
    step();
    check("rst_data", o_data, 0);
    check("rst_row", o_row, 0);
    check("rst_col", o_col, 0);
    i_reset = 1'b0;

    // 1: all finish together, values k+1, full-rate drain.
    for (int k = 0; k < N; k++) set_c(k, OB'(k + 1));
    i_ready  = 1'b1;
    i_finish = '1;
    step();
    i_finish = '0;
    check("s1_first_valid", o_valid, 1);
    check("s1_first_data", o_data, 1);
    xfers = 0;
    drain_out(20);
    check("s1_xfers", xfers, N);

    // 2: diagonal wavefront; the last PE finishes at cycle 6, so output starts at cycle 7.
    for (int cyc = 0; cyc < 7; cyc++) begin
      i_finish = '0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          if (r + c == cyc) begin
            i_finish[r*DIM + c] = 1'b1;
            set_c(r*DIM + c, OB'(100 * (r*DIM + c) + 7));
          end
      if (cyc == 6) check("s2_not_early", o_valid, 0);
      step();
    end
    check("s2_latency", o_valid, 1);
    check("s2_first_data", o_data, 7);
    drain_out(20);

    // 3: ready alternates, one transfer per two cycles.
    fill_random();
    xfers = 0;
    for (int i = 0; i < 2 * N; i++) begin
      i_ready = (i % 2 == 0);
      step();
    end
    check("s3_xfers", xfers, N);
    check("s3_empty", o_valid, 0);

    // 4: element 5 finishes twice during collect; the first value survives.
    i_ready  = 1'b1;
    i_finish = '0;
    i_finish[5] = 1'b1;
    set_c(5, OB'(18'h111));
    step();
    set_c(5, OB'(18'h222));
    step();
    check("s4_overrun", o_overrun, 1);
    i_finish = ~(N'(1) << 5);
    for (int k = 0; k < N; k++) if (k != 5) set_c(k, OB'($urandom));
    step();
    i_finish = '0;
    for (int i = 0; i < 5; i++) step();
    check("s4_elem5", o_data, 18'h111);
    drain_out(20);

    // 5: a finish pulse during drain is dropped and flagged.
    do_reset();
    check("s5_clear", o_overrun, 0);
    fill_random();
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    i_finish[0] = 1'b1;
    set_c(0, OB'($urandom));
    step();
    i_finish = '0;
    drain_out(20);
    check("s5_overrun", o_overrun, 1);

    // 6: reset after five transfers abandons the batch.
    fill_random();
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    check("s6_valid", o_valid, 0);
    check("s6_overrun", o_overrun, 0);
    fill_random();
    check("s6_row", o_row, 0);
    check("s6_col", o_col, 0);
    drain_out(20);

    // Random traffic: sparse finish pulses, random ready, occasional reset.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        i_finish[k] = ($urandom_range(0, 5) == 0);
        set_c(k, OB'($urandom));
      end
      i_ready = $urandom_range(0, 1) == 1;
      i_reset = ($urandom_range(0, 149) == 0);
      step();
    end
    i_reset = 1'b0;
    drain_out(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
